skin_bbox_detect: RTL and testbench

//  Consumes the Y/Cb/Cr pixel stream from the colour-space stage and classifies each pixel as skin with a Cb/Cr window.

---
 rtl/skin_bbox_detect_pkg.sv | 43 ++++
 rtl/skin_bbox_detect_frame_xy_counter.sv | 61 ++++++
 rtl/skin_bbox_detect.sv | 172 +++++++++++++++++
 tb/tb_skin_bbox_detect.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skin_bbox_detect_pkg.sv
// skin_pkg: constants and types shared by the skin detector and the downstream
// gesture classifier.
//   COORD_W / CNT_W   widths of box coordinates and skin pixel count
//   *_DEF             default frame geometry and Cb/Cr skin window
//   BOX_INIT_MIN      start value of the min trackers; any real coordinate is smaller
//   box_t             bounding box plus pixel count, used for accumulators and results
package skin_pkg;

    localparam int COORD_W = 11;
    localparam int CNT_W   = 20;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int CB_MIN_DEF     = 80;
    localparam int CB_MAX_DEF     = 130;
    localparam int CR_MIN_DEF     = 140;
    localparam int CR_MAX_DEF     = 180;
    localparam int MIN_PIXELS_DEF = 256;

    localparam logic [COORD_W-1:0] BOX_INIT_MIN = 11'h7FF;
    localparam logic [COORD_W-1:0] COORD_MAX    = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
        logic [CNT_W-1:0]   cnt;
    } box_t;

    // Accumulator state at the start of a frame: empty box, zero count.
    function automatic box_t box_init();
        box_t b;
        b.x_min = BOX_INIT_MIN;
        b.x_max = '0;
        b.y_min = BOX_INIT_MIN;
        b.y_max = '0;
        b.cnt   = '0;
        return b;
    endfunction

endpackage

// File: rtl/skin_bbox_detect_frame_xy_counter.sv
// frame_xy_counter: tracks the pixel coordinate of the current cycle from de/vsync.
//   clk, rst        pixel clock, asynchronous active-high reset
//   vsync_i, de_i   sync signals (already aligned with the skin mask)
//   x_o, y_o        coordinate of the pixel presented this cycle (saturating)
//   in_range_o      de high and coordinate inside the active window
//   frame_start_o   vsync rising edge on this cycle
module frame_xy_counter
    import skin_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync_i,
    input  logic               de_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               in_range_o,
    output logic               frame_start_o
);

    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

    logic               vs_q;
    logic               de_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               de_fall;

    assign frame_start_o = vsync_i & ~vs_q;
    assign de_fall       = de_q & ~de_i;

    // x/y hold the coordinate of the pixel seen this cycle; they advance afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q <= 1'b0;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            vs_q <= vsync_i;
            de_q <= de_i;
            if (de_fall)
                x_q <= '0;
            else if (de_i && x_q != COORD_MAX)
                x_q <= x_q + 1'b1;
            // frame start has priority over a line end on the same cycle
            if (frame_start_o)
                y_q <= '0;
            else if (de_fall && y_q != COORD_MAX)
                y_q <= y_q + 1'b1;
        end
    end

    assign x_o        = x_q;
    assign y_o        = y_q;
    assign in_range_o = de_i && (x_q < H_LIM) && (y_q < V_LIM);

endmodule

// File: rtl/skin_bbox_detect.sv
// skin_bbox_detect: Cb/Cr window skin classifier with per-frame bounding box.
//   clk, rst                       pixel clock, asynchronous active-high reset
//   pre_frame_vsync/hsync/de       input syncs; vsync rising edge starts a frame
//   img_y, img_cb, img_cr          pixel components (luma is not used)
//   post_frame_vsync/hsync/de      syncs delayed by 2 cycles
//   skin_bin                       skin mask aligned with the delayed syncs
//   bbox_valid                     one-cycle pulse when the result registers update
//   x_min/x_max/y_min/y_max        skin box of the last completed frame
//   pixel_count, hand_present      skin count (saturating) and count >= MIN_PIXELS
module skin_bbox_detect
    import skin_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int CB_MIN     = CB_MIN_DEF,
    parameter int CB_MAX     = CB_MAX_DEF,
    parameter int CR_MIN     = CR_MIN_DEF,
    parameter int CR_MAX     = CR_MAX_DEF,
    parameter int MIN_PIXELS = MIN_PIXELS_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               pre_frame_vsync,
    input  logic               pre_frame_hsync,
    input  logic               pre_frame_de,
    input  logic [7:0]         img_y,
    input  logic [7:0]         img_cb,
    input  logic [7:0]         img_cr,
    output logic               post_frame_vsync,
    output logic               post_frame_hsync,
    output logic               post_frame_de,
    output logic               skin_bin,
    output logic               bbox_valid,
    output logic [COORD_W-1:0] x_min,
    output logic [COORD_W-1:0] x_max,
    output logic [COORD_W-1:0] y_min,
    output logic [COORD_W-1:0] y_max,
    output logic [CNT_W-1:0]   pixel_count,
    output logic               hand_present
);

    localparam logic [7:0]       CB_LO   = 8'(CB_MIN);
    localparam logic [7:0]       CB_HI   = 8'(CB_MAX);
    localparam logic [7:0]       CR_LO   = 8'(CR_MIN);
    localparam logic [7:0]       CR_HI   = 8'(CR_MAX);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    // Luma is carried on the interface but plays no part in classification.
    logic unused_luma;
    assign unused_luma = ^img_y;

    // ---------------- pixel path ----------------
    logic [3:0] cmp_q;
    logic       skin_q;
    logic [1:0] vs_sr_q;
    logic [1:0] hs_sr_q;
    logic [1:0] de_sr_q;

    // de_sr_q[0] is the stage-1 data enable, bit 1 the stage-2 copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_q   <= '0;
            skin_q  <= 1'b0;
            vs_sr_q <= '0;
            hs_sr_q <= '0;
            de_sr_q <= '0;
        end else begin
            cmp_q   <= {img_cb > CB_LO, img_cb < CB_HI, img_cr > CR_LO, img_cr < CR_HI};
            skin_q  <= de_sr_q[0] & (&cmp_q);
            vs_sr_q <= {vs_sr_q[0], pre_frame_vsync};
            hs_sr_q <= {hs_sr_q[0], pre_frame_hsync};
            de_sr_q <= {de_sr_q[0], pre_frame_de};
        end
    end

    assign post_frame_vsync = vs_sr_q[1];
    assign post_frame_hsync = hs_sr_q[1];
    assign post_frame_de    = de_sr_q[1];
    assign skin_bin         = skin_q;

    // ---------------- coordinates on the delayed stream ----------------
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               in_range;
    logic               frame_start;

    frame_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_xy (
        .clk           (clk),
        .rst           (rst),
        .vsync_i       (vs_sr_q[1]),
        .de_i          (de_sr_q[1]),
        .x_o           (cur_x),
        .y_o           (cur_y),
        .in_range_o    (in_range),
        .frame_start_o (frame_start)
    );

    // ---------------- accumulation and publishing ----------------
    box_t acc_q, acc_d, fold;
    box_t res_q, res_d;
    logic hand_q, hand_d;
    logic valid_q, valid_d;
    logic frame_seen_q, frame_seen_d;
    logic pix_ok;

    assign pix_ok = skin_q & in_range;

    // Accumulators with this cycle's pixel folded in. The snapshot at a frame
    // boundary uses these, so a skin pixel on the vsync edge cycle belongs to
    // the frame that is closing.
    always_comb begin
        fold = acc_q;
        if (pix_ok) begin
            if (acc_q.cnt != CNT_MAX) fold.cnt = acc_q.cnt + 1'b1;
            if (cur_x < acc_q.x_min)  fold.x_min = cur_x;
            if (cur_x > acc_q.x_max)  fold.x_max = cur_x;
            if (cur_y < acc_q.y_min)  fold.y_min = cur_y;
            if (cur_y > acc_q.y_max)  fold.y_max = cur_y;
        end
    end

    always_comb begin
        acc_d        = fold;
        res_d        = res_q;
        hand_d       = hand_q;
        valid_d      = 1'b0;
        frame_seen_d = frame_seen_q;
        if (frame_start) begin
            acc_d        = box_init();
            frame_seen_d = 1'b1;
            // the partial frame before the first boundary is never published
            if (frame_seen_q) begin
                valid_d = 1'b1;
                if (fold.cnt == '0) begin
                    res_d  = '0;
                    hand_d = 1'b0;
                end else begin
                    res_d  = fold;
                    hand_d = (fold.cnt >= MIN_CNT);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= box_init();
            res_q        <= '0;
            hand_q       <= 1'b0;
            valid_q      <= 1'b0;
            frame_seen_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            res_q        <= res_d;
            hand_q       <= hand_d;
            valid_q      <= valid_d;
            frame_seen_q <= frame_seen_d;
        end
    end

    assign bbox_valid   = valid_q;
    assign x_min        = res_q.x_min;
    assign x_max        = res_q.x_max;
    assign y_min        = res_q.y_min;
    assign y_max        = res_q.y_max;
    assign pixel_count  = res_q.cnt;
    assign hand_present = hand_q;

endmodule

// File: tb/tb_skin_bbox_detect.sv
module tb_skin_bbox_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pre_frame_vsync = 1'b0;
    logic        pre_frame_hsync = 1'b0;
    logic        pre_frame_de = 1'b0;
    logic [7:0]  img_y = 8'd0;
    logic [7:0]  img_cb = 8'd128;
    logic [7:0]  img_cr = 8'd128;
    logic        post_frame_vsync, post_frame_hsync, post_frame_de, skin_bin, bbox_valid;
    logic [10:0] x_min, x_max, y_min, y_max;
    logic [19:0] pixel_count;
    logic        hand_present;

    always #5 clk = ~clk;

    skin_bbox_detect dut (
        .clk              (clk),
        .rst              (rst),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_hsync  (pre_frame_hsync),
        .pre_frame_de     (pre_frame_de),
        .img_y            (img_y),
        .img_cb           (img_cb),
        .img_cr           (img_cr),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_de    (post_frame_de),
        .skin_bin         (skin_bin),
        .bbox_valid       (bbox_valid),
        .x_min            (x_min),
        .x_max            (x_max),
        .y_min            (y_min),
        .y_max            (y_max),
        .pixel_count      (pixel_count),
        .hand_present     (hand_present)
    );

    typedef struct {
        int xmin; int xmax; int ymin; int ymax; int cnt; int hp;
    } exp_box_t;

    exp_box_t   box_q[$];
    logic [3:0] pipe_q[$];
    int checks = 0;
    int failures = 0;

    // reference model state: coordinate of the pixel being driven and frame accumulators
    int mx, my, axmin, axmax, aymin, aymax, acnt;
    bit pvs, pde, seen;
    int skin_seen_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        axmin = 2047; axmax = 0; aymin = 2047; aymax = 0; acnt = 0;
    endtask

    task automatic model_reset();
        mx = 0; my = 0; pvs = 0; pde = 0; seen = 0;
        model_init();
        pipe_q.delete();
        box_q.delete();
    endtask

    // Drive one cycle, update the model, then sample one step after the edge.
    task automatic tick(input bit vs, input bit hs, input bit de, input logic [7:0] cb, input logic [7:0] cr);
        bit sk;
        bit edge_v;
        bit fall;
        exp_box_t b;
        logic [3:0] e;
        sk = de && cb > 8'd80 && cb < 8'd130 && cr > 8'd140 && cr < 8'd180;
        pre_frame_vsync = vs; pre_frame_hsync = hs; pre_frame_de = de;
        img_cb = cb; img_cr = cr; img_y = cb ^ cr;
        pipe_q.push_back({vs, hs, de, sk});
        if (sk && mx < 640 && my < 480) begin
            if (acnt < 20'hFFFFF) acnt++;
            if (mx < axmin) axmin = mx;
            if (mx > axmax) axmax = mx;
            if (my < aymin) aymin = my;
            if (my > aymax) aymax = my;
        end
        edge_v = vs && !pvs;
        if (edge_v) begin
            if (seen) begin
                if (acnt == 0) b = '{0, 0, 0, 0, 0, 0};
                else b = '{axmin, axmax, aymin, aymax, acnt, (acnt >= 256) ? 1 : 0};
                box_q.push_back(b);
            end
            model_init();
            seen = 1;
        end
        fall = !de && pde;
        if (fall) mx = 0; else if (de && mx < 2047) mx++;
        if (edge_v) my = 0; else if (fall && my < 2047) my++;
        pvs = vs; pde = de;
        @(posedge clk); #1;
        if (pipe_q.size() == 2) begin
            e = pipe_q.pop_front();
            check("sync_skin_pipe", 32'({post_frame_vsync, post_frame_hsync, post_frame_de, skin_bin}), 32'(e));
        end
        if (skin_bin) skin_seen_cnt++;
        if (bbox_valid) begin
            if (box_q.size() == 0) begin
                check("bbox_valid_unexpected", 32'(bbox_valid), 32'd0);
            end else begin
                b = box_q.pop_front();
                check("x_min", 32'(x_min), b.xmin);
                check("x_max", 32'(x_max), b.xmax);
                check("y_min", 32'(y_min), b.ymin);
                check("y_max", 32'(y_max), b.ymax);
                check("pixel_count", 32'(pixel_count), b.cnt);
                check("hand_present", 32'(hand_present), b.hp);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 8'd128, 8'd128);
    endtask

    // One line of len pixels; x in [s_lo,s_hi] gets the first colour, else the second.
    task automatic line(input int len, input int s_lo, input int s_hi,
                        input logic [7:0] cb_s, input logic [7:0] cr_s,
                        input logic [7:0] cb_n, input logic [7:0] cr_n);
        for (int i = 0; i < len; i++) begin
            if (i >= s_lo && i <= s_hi) tick(0, 0, 1, cb_s, cr_s);
            else tick(0, 0, 1, cb_n, cr_n);
        end
        tick(0, 1, 0, 8'd128, 8'd128);
    endtask

    task automatic skin_line(input int len, input int s_lo, input int s_hi);
        line(len, s_lo, s_hi, 8'd100, 8'd160, 8'd128, 8'd128);
    endtask

    // vsync pulse, then enough idle for the result pulse to emerge.
    task automatic frame_end();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 8'd128, 8'd128);
        idle(4);
        check("bbox_pulse_pending", 32'(box_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        check("rst_bbox_valid", 32'(bbox_valid), 32'd0);
        check("rst_pixel_count", 32'(pixel_count), 32'd0);
        check("rst_x_max", 32'(x_max), 32'd0);
        check("rst_y_max", 32'(y_max), 32'd0);
        check("rst_hand_present", 32'(hand_present), 32'd0);
        check("rst_skin_post_de", 32'({skin_bin, post_frame_de}), 32'd0);
        model_reset();
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        // 1) reset, release mid-frame: first edge silent, second edge publishes
        do_reset(5);
        skin_line(30, 0, 29);
        skin_line(30, 0, 29);
        check("post_reset_x_min", 32'(x_min), 32'd0);
        check("post_reset_count", 32'(pixel_count), 32'd0);
        frame_end();

        // 2) rectangle x 100..199, y 50..149
        for (int y = 0; y < 50; y++) skin_line(1, 1, 0);
        for (int y = 50; y < 150; y++) skin_line(200, 100, 199);
        frame_end();
        check("t2_x_min", 32'(x_min), 32'd100);
        check("t2_x_max", 32'(x_max), 32'd199);
        check("t2_y_min", 32'(y_min), 32'd50);
        check("t2_y_max", 32'(y_max), 32'd149);
        check("t2_count", 32'(pixel_count), 32'd10000);
        check("t2_hand", 32'(hand_present), 32'd1);

        // 3) window boundary values are never skin
        skin_seen_cnt = 0;
        line(50, 0, 49, 8'd80, 8'd160, 8'd128, 8'd128);
        line(50, 0, 49, 8'd130, 8'd160, 8'd128, 8'd128);
        line(50, 0, 49, 8'd100, 8'd140, 8'd128, 8'd128);
        line(50, 0, 49, 8'd100, 8'd180, 8'd128, 8'd128);
        check("t3_hold_x_min", 32'(x_min), 32'd100);
        frame_end();
        check("t3_skin_bin_highs", 32'(skin_seen_cnt), 32'd0);
        check("t3_count", 32'(pixel_count), 32'd0);
        check("t3_x_min", 32'(x_min), 32'd0);
        check("t3_hand", 32'(hand_present), 32'd0);

        // 4) single skin pixel at (639,479)
        for (int y = 0; y < 479; y++) skin_line(1, 1, 0);
        skin_line(640, 639, 639);
        frame_end();
        check("t4_x_min", 32'(x_min), 32'd639);
        check("t4_x_max", 32'(x_max), 32'd639);
        check("t4_y_min", 32'(y_min), 32'd479);
        check("t4_y_max", 32'(y_max), 32'd479);
        check("t4_count", 32'(pixel_count), 32'd1);
        check("t4_hand", 32'(hand_present), 32'd0);

        // 5) over-long lines: columns >= 640 excluded
        for (int y = 0; y < 3; y++) skin_line(700, 0, 699);
        frame_end();
        check("t5_x_max", 32'(x_max), 32'd639);
        check("t5_count", 32'(pixel_count), 32'd1920);
        check("t5_hand", 32'(hand_present), 32'd1);

        // 6) skin pixel on the vsync edge cycle joins the closing frame
        for (int y = 0; y < 3; y++) skin_line(10, 0, 9);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 8'd128, 8'd128);
        tick(1, 0, 1, 8'd100, 8'd160);
        tick(1, 0, 0, 8'd128, 8'd128);
        tick(1, 0, 0, 8'd128, 8'd128);
        idle(4);
        check("t6_close_count", 32'(pixel_count), 32'd31);
        check("t6_close_y_max", 32'(y_max), 32'd3);
        skin_line(3, 0, 2);
        frame_end();
        check("t6_next_count", 32'(pixel_count), 32'd3);

        // mid-frame reset: clears results, next edge silent
        skin_line(20, 0, 19);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 8'd100, 8'd160);
        do_reset(3);
        skin_line(20, 0, 19);
        frame_end();
        check("rst2_silent_count", 32'(pixel_count), 32'd0);
        skin_line(5, 0, 4);
        frame_end();
        check("rst2_count", 32'(pixel_count), 32'd5);
        check("rst2_x_max", 32'(x_max), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
